// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry/exit barrier control. Each car produces one serialized event pulse toward the occupancy counter.
// Optional PARK_GATE_STATS_EN adds saturating deny_count/timeout_count outputs.
module parking_gate_ctrl #(
    parameter int unsigned OPEN_HOUR   = 8,
    parameter int unsigned PULSE_CYC   = 2,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  hour,
    input  logic        entry_req,
    input  logic        entry_is_uni,
    input  logic        entry_passed,
    input  logic        exit_req,
    input  logic        exit_is_uni,
    input  logic        exit_passed,
    input  logic        uni_is_vacated_space,
    input  logic        is_vacated_space,
    output logic        entry_gate_open,
    output logic        exit_gate_open,
    output logic        entry_denied,
    output logic        car_entered,
    output logic        is_uni_car_entered,
    output logic        car_exited,
`ifdef PARK_GATE_STATS_EN
    output logic        is_uni_car_exited,
    output logic [15:0] deny_count,
    output logic [15:0] timeout_count
`else
    output logic        is_uni_car_exited
`endif
);
    localparam logic [5:0]  OPEN_H   = 6'(OPEN_HOUR);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] P_LAST   = 16'(PULSE_CYC - 1);

    typedef enum logic [2:0] {E_IDLE, E_CHECK, E_OPEN, E_REPORT, E_WAIT_CLR} e_state_t;
    typedef enum logic [1:0] {X_IDLE, X_OPEN, X_REPORT, X_WAIT_CLR} x_state_t;
    typedef enum logic [1:0] {P_IDLE, P_HIGH, P_GAP} p_state_t;

    e_state_t    e_state_q, e_state_d;
    x_state_t    x_state_q, x_state_d;
    p_state_t    p_state_q, p_state_d;
    logic [15:0] e_timer_q, e_timer_d;
    logic [15:0] x_timer_q, x_timer_d;
    logic [15:0] p_cnt_q, p_cnt_d;
    logic        e_uni_q, e_uni_d;
    logic        x_uni_q, x_uni_d;
    logic        entry_gate_open_q, entry_gate_open_d;
    logic        exit_gate_open_q, exit_gate_open_d;
    logic        entry_denied_q, entry_denied_d;
    logic        car_entered_q, car_entered_d;
    logic        car_exited_q, car_exited_d;
    logic        tag_entered_q, tag_entered_d;
    logic        tag_exited_q, tag_exited_d;
    logic        e_tmo, x_tmo, p_free, grant_x, grant_e;
`ifdef PARK_GATE_STATS_EN
    logic [15:0] deny_count_q, deny_count_d;
    logic [15:0] timeout_count_q, timeout_count_d;
    logic [1:0]  tmo_inc;
    logic [16:0] tmo_sum;
`endif

    // The last gap cycle also counts as free so back-to-back events see exactly PULSE_CYC low cycles.
    assign p_free  = (p_state_q == P_IDLE) || (p_state_q == P_GAP && p_cnt_q == P_LAST);
    assign grant_x = p_free && (x_state_q == X_REPORT);
    assign grant_e = p_free && (e_state_q == E_REPORT) && !grant_x;

    always_comb begin
        e_state_d         = e_state_q;
        x_state_d         = x_state_q;
        p_state_d         = p_state_q;
        e_timer_d         = e_timer_q;
        x_timer_d         = x_timer_q;
        p_cnt_d           = p_cnt_q;
        e_uni_d           = e_uni_q;
        x_uni_d           = x_uni_q;
        entry_gate_open_d = entry_gate_open_q;
        exit_gate_open_d  = exit_gate_open_q;
        entry_denied_d    = 1'b0;
        car_entered_d     = car_entered_q;
        car_exited_d      = car_exited_q;
        tag_entered_d     = tag_entered_q;
        tag_exited_d      = tag_exited_q;
        e_tmo             = 1'b0;
        x_tmo             = 1'b0;

        case (e_state_q)
            E_IDLE: if (entry_req && hour >= OPEN_H) begin
                e_state_d = E_CHECK;
                e_uni_d   = entry_is_uni;
            end
            E_CHECK: if (e_uni_q ? (uni_is_vacated_space | is_vacated_space) : is_vacated_space) begin
                e_state_d         = E_OPEN;
                e_timer_d         = '0;
                entry_gate_open_d = 1'b1;
            end else begin
                e_state_d      = E_WAIT_CLR;
                entry_denied_d = 1'b1;
            end
            E_OPEN: if (entry_passed) begin
                e_state_d         = E_REPORT;
                entry_gate_open_d = 1'b0;
            end else if (e_timer_q == TMO_LAST) begin
                e_state_d         = E_WAIT_CLR;
                entry_gate_open_d = 1'b0;
                e_tmo             = 1'b1;
            end else if (e_timer_q != '1) begin
                e_timer_d = e_timer_q + 16'd1;
            end
            E_REPORT:   if (grant_e) e_state_d = E_WAIT_CLR;
            E_WAIT_CLR: if (!entry_req) e_state_d = E_IDLE;
            default:    e_state_d = E_IDLE;
        endcase

        case (x_state_q)
            X_IDLE: if (exit_req) begin
                x_state_d        = X_OPEN;
                x_uni_d          = exit_is_uni;
                x_timer_d        = '0;
                exit_gate_open_d = 1'b1;
            end
            X_OPEN: if (exit_passed) begin
                x_state_d        = X_REPORT;
                exit_gate_open_d = 1'b0;
            end else if (x_timer_q == TMO_LAST) begin
                x_state_d        = X_WAIT_CLR;
                exit_gate_open_d = 1'b0;
                x_tmo            = 1'b1;
            end else if (x_timer_q != '1) begin
                x_timer_d = x_timer_q + 16'd1;
            end
            X_REPORT:   if (grant_x) x_state_d = X_WAIT_CLR;
            X_WAIT_CLR: if (!exit_req) x_state_d = X_IDLE;
            default:    x_state_d = X_IDLE;
        endcase

        case (p_state_q)
            P_HIGH: if (p_cnt_q == P_LAST) begin
                p_state_d     = P_GAP;
                p_cnt_d       = '0;
                car_entered_d = 1'b0;
                car_exited_d  = 1'b0;
            end else begin
                p_cnt_d = p_cnt_q + 16'd1;
            end
            P_GAP: if (p_cnt_q == P_LAST) begin
                p_state_d = P_IDLE;
            end else begin
                p_cnt_d = p_cnt_q + 16'd1;
            end
            default: p_state_d = P_IDLE;
        endcase

        if (grant_x) begin
            p_state_d    = P_HIGH;
            p_cnt_d      = '0;
            car_exited_d = 1'b1;
            tag_exited_d = x_uni_q;
        end else if (grant_e) begin
            p_state_d     = P_HIGH;
            p_cnt_d       = '0;
            car_entered_d = 1'b1;
            tag_entered_d = e_uni_q;
        end
`ifdef PARK_GATE_STATS_EN
        deny_count_d = deny_count_q;
        if (entry_denied_d && deny_count_q != '1)
            deny_count_d = deny_count_q + 16'd1;
        tmo_inc         = {1'b0, e_tmo} + {1'b0, x_tmo};
        tmo_sum         = {1'b0, timeout_count_q} + {15'b0, tmo_inc};
        timeout_count_d = tmo_sum[16] ? '1 : tmo_sum[15:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_state_q         <= E_IDLE;
            x_state_q         <= X_IDLE;
            p_state_q         <= P_IDLE;
            e_timer_q         <= '0;
            x_timer_q         <= '0;
            p_cnt_q           <= '0;
            e_uni_q           <= 1'b0;
            x_uni_q           <= 1'b0;
            entry_gate_open_q <= 1'b0;
            exit_gate_open_q  <= 1'b0;
            entry_denied_q    <= 1'b0;
            car_entered_q     <= 1'b0;
            car_exited_q      <= 1'b0;
            tag_entered_q     <= 1'b0;
            tag_exited_q      <= 1'b0;
`ifdef PARK_GATE_STATS_EN
            deny_count_q      <= '0;
            timeout_count_q   <= '0;
`endif
        end else begin
            e_state_q         <= e_state_d;
            x_state_q         <= x_state_d;
            p_state_q         <= p_state_d;
            e_timer_q         <= e_timer_d;
            x_timer_q         <= x_timer_d;
            p_cnt_q           <= p_cnt_d;
            e_uni_q           <= e_uni_d;
            x_uni_q           <= x_uni_d;
            entry_gate_open_q <= entry_gate_open_d;
            exit_gate_open_q  <= exit_gate_open_d;
            entry_denied_q    <= entry_denied_d;
            car_entered_q     <= car_entered_d;
            car_exited_q      <= car_exited_d;
            tag_entered_q     <= tag_entered_d;
            tag_exited_q      <= tag_exited_d;
`ifdef PARK_GATE_STATS_EN
            deny_count_q      <= deny_count_d;
            timeout_count_q   <= timeout_count_d;
`endif
        end
    end

    assign entry_gate_open    = entry_gate_open_q;
    assign exit_gate_open     = exit_gate_open_q;
    assign entry_denied       = entry_denied_q;
    assign car_entered        = car_entered_q;
    assign is_uni_car_entered = tag_entered_q;
    assign car_exited         = car_exited_q;
    assign is_uni_car_exited  = tag_exited_q;
`ifdef PARK_GATE_STATS_EN
    assign deny_count         = deny_count_q;
    assign timeout_count      = timeout_count_q;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Testbench for parking_gate_ctrl: scenario tasks with randomized cars checked against lane rules.
module tb_parking_gate_ctrl;
    localparam int OPEN_HOUR   = 8;
    localparam int PULSE_CYC   = 2;
    localparam int TIMEOUT_CYC = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] hour = '0;
    logic       entry_req = 1'b0, entry_is_uni = 1'b0, entry_passed = 1'b0;
    logic       exit_req = 1'b0, exit_is_uni = 1'b0, exit_passed = 1'b0;
    logic       uni_is_vacated_space = 1'b0, is_vacated_space = 1'b0;
    logic       entry_gate_open, exit_gate_open, entry_denied;
    logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
`ifdef PARK_GATE_STATS_EN
    logic [15:0] deny_count, timeout_count;
`endif

    int checks = 0;
    int passes = 0;
    int ent_rises = 0, ex_rises = 0, overlap_cnt = 0;
    logic ent_prev = 1'b0, ex_prev = 1'b0;

    parking_gate_ctrl #(
        .OPEN_HOUR(OPEN_HOUR),
        .PULSE_CYC(PULSE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hour(hour),
        .entry_req(entry_req),
        .entry_is_uni(entry_is_uni),
        .entry_passed(entry_passed),
        .exit_req(exit_req),
        .exit_is_uni(exit_is_uni),
        .exit_passed(exit_passed),
        .uni_is_vacated_space(uni_is_vacated_space),
        .is_vacated_space(is_vacated_space),
        .entry_gate_open(entry_gate_open),
        .exit_gate_open(exit_gate_open),
        .entry_denied(entry_denied),
        .car_entered(car_entered),
        .is_uni_car_entered(is_uni_car_entered),
        .car_exited(car_exited),
`ifdef PARK_GATE_STATS_EN
        .deny_count(deny_count),
        .timeout_count(timeout_count),
`endif
        .is_uni_car_exited(is_uni_car_exited)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping observed away from the active edge.
    always @(negedge clk) begin
        if (car_entered === 1'b1 && car_exited === 1'b1) overlap_cnt <= overlap_cnt + 1;
        if (car_entered === 1'b1 && ent_prev !== 1'b1) ent_rises <= ent_rises + 1;
        if (car_exited === 1'b1 && ex_prev !== 1'b1) ex_rises <= ex_rises + 1;
        ent_prev <= car_entered;
        ex_prev  <= car_exited;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", passes, checks);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        entry_req = 0; entry_is_uni = 0; entry_passed = 0;
        exit_req = 0; exit_is_uni = 0; exit_passed = 0;
        uni_is_vacated_space = 0; is_vacated_space = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        clear_inputs();
        repeat (3) tick();
        rst_n = 1;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        tick();
        checks++;
        if ({entry_gate_open, exit_gate_open, entry_denied, car_entered, is_uni_car_entered,
             car_exited, is_uni_car_exited} !== 7'b0)
            $display("FAIL reset_outputs: got %b need 0000000", {entry_gate_open, exit_gate_open,
                     entry_denied, car_entered, is_uni_car_entered, car_exited, is_uni_car_exited});
        else passes++;
`ifdef PARK_GATE_STATS_EN
        checks++;
        if (deny_count !== 16'd0 || timeout_count !== 16'd0)
            $display("FAIL reset_stats: got %0d/%0d need 0/0", deny_count, timeout_count);
        else passes++;
`endif
        rst_n = 1;
        repeat (2) tick();
    endtask

    task automatic test_public_entry();
        int n, r0;
        logic seen;
        hour = 6'($urandom_range(23, OPEN_HOUR));
        is_vacated_space = 1;
        uni_is_vacated_space = 1'($urandom_range(1, 0));
        entry_is_uni = 0;
        r0 = ent_rises;
        entry_req = 1;
        n = 0; seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick(); n++; seen = entry_gate_open;
        end
        checks++;
        if (seen !== 1'b1 || n != 2) $display("FAIL entry_open_latency: got seen=%b n=%0d need 1/2", seen, n);
        else passes++;
        repeat ($urandom_range(4, 1)) tick();
        checks++;
        if (entry_gate_open !== 1'b1) $display("FAIL entry_gate_held: got %b need 1", entry_gate_open);
        else passes++;
        entry_passed = 1; tick(); entry_passed = 0;
        checks++;
        if (car_entered !== 1'b0 || entry_gate_open !== 1'b0)
            $display("FAIL entry_pre_pulse: got pulse=%b gate=%b need 0/0", car_entered, entry_gate_open);
        else passes++;
        tick();
        checks++;
        if (car_entered !== 1'b1 || is_uni_car_entered !== 1'b0)
            $display("FAIL entry_pulse_n2: got pulse=%b tag=%b need 1/0", car_entered, is_uni_car_entered);
        else passes++;
        tick();
        checks++;
        if (car_entered !== 1'b1) $display("FAIL entry_pulse_hold: got %b need 1", car_entered);
        else passes++;
        tick();
        checks++;
        if (car_entered !== 1'b0) $display("FAIL entry_pulse_end: got %b need 0", car_entered);
        else passes++;
        entry_req = 0;
        repeat (6) tick();
        checks++;
        if (ent_rises - r0 != 1) $display("FAIL entry_pulse_count: got %0d need 1", ent_rises - r0);
        else passes++;
    endtask

    task automatic test_hour_gate();
        logic gate_seen, deny_seen, seen;
        hour = 6'($urandom_range(OPEN_HOUR - 1, 0));
        is_vacated_space = 1; entry_is_uni = 0;
        entry_req = 1;
        gate_seen = 0; deny_seen = 0;
        repeat (20) begin
            tick();
            gate_seen |= entry_gate_open;
            deny_seen |= entry_denied;
        end
        checks++;
        if (gate_seen !== 1'b0 || deny_seen !== 1'b0)
            $display("FAIL early_hour_blocked: got gate=%b deny=%b need 0/0 (hour %0d)", gate_seen, deny_seen, hour);
        else passes++;
        hour = 6'(OPEN_HOUR);
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick(); seen = entry_gate_open;
        end
        checks++;
        if (seen !== 1'b1) $display("FAIL open_at_hour8: got %b need 1", seen);
        else passes++;
        entry_passed = 1; tick(); entry_passed = 0;
        repeat (6) tick();
        entry_req = 0;
        repeat (4) tick();
    endtask

    task automatic test_denied();
        int unsigned off;
        int n_denied, deny_cyc;
        logic [2:0] combo;
        logic uni, uf, pf, ok, gate_seen, got, tagv;
        apply_reset();
        off = $urandom_range(7, 0);
        n_denied = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            combo = 3'((i + off) % 8);
            uni = combo[2]; uf = combo[1]; pf = combo[0];
            ok = uni ? (uf | pf) : pf;
            if (!ok) n_denied++;
            hour = 6'($urandom_range(23, OPEN_HOUR));
            entry_is_uni = uni; uni_is_vacated_space = uf; is_vacated_space = pf;
            entry_req = 1;
            gate_seen = 0; deny_cyc = 0;
            repeat (8) begin
                tick();
                gate_seen |= entry_gate_open;
                if (entry_denied === 1'b1) deny_cyc++;
            end
            checks++;
            if (gate_seen !== ok) $display("FAIL vacancy_gate_c%0d: got %b need %b", combo, gate_seen, ok);
            else passes++;
            checks++;
            if (deny_cyc != (ok ? 0 : 1)) $display("FAIL vacancy_deny_c%0d: got %0d cycles need %0d", combo, deny_cyc, ok ? 0 : 1);
            else passes++;
            if (ok) begin
                entry_passed = 1; tick(); entry_passed = 0;
                got = 0; tagv = 0;
                for (int j = 0; j < 10 && !got; j++) begin
                    tick();
                    if (car_entered === 1'b1) begin got = 1; tagv = is_uni_car_entered; end
                end
                checks++;
                if (got !== 1'b1 || tagv !== uni) $display("FAIL vacancy_tag_c%0d: got pulse=%b tag=%b need 1/%b", combo, got, tagv, uni);
                else passes++;
            end
            entry_req = 0;
            repeat (6) tick();
        end
`ifdef PARK_GATE_STATS_EN
        checks++;
        if (deny_count !== 16'(n_denied)) $display("FAIL deny_count: got %0d need %0d", deny_count, n_denied);
        else passes++;
`endif
    endtask

    task automatic test_both_pass();
        logic eu, xu, te, tx;
        int fe, fx, ne, nx, ovl;
        hour = 12; is_vacated_space = 1; uni_is_vacated_space = 1;
        eu = 1'($urandom_range(1, 0)); xu = 1'($urandom_range(1, 0));
        entry_is_uni = eu; exit_is_uni = xu;
        entry_req = 1; exit_req = 1;
        repeat (4) tick();
        checks++;
        if (entry_gate_open !== 1'b1 || exit_gate_open !== 1'b1)
            $display("FAIL both_gates_open: got %b%b need 11", entry_gate_open, exit_gate_open);
        else passes++;
        entry_passed = 1; exit_passed = 1; tick(); entry_passed = 0; exit_passed = 0;
        fe = -1; fx = -1; ne = 0; nx = 0; ovl = 0; te = 0; tx = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (car_entered === 1'b1) begin ne++; if (fe < 0) begin fe = i; te = is_uni_car_entered; end end
            if (car_exited === 1'b1) begin nx++; if (fx < 0) begin fx = i; tx = is_uni_car_exited; end end
            if (car_entered === 1'b1 && car_exited === 1'b1) ovl++;
        end
        checks++;
        if (fx != 0) $display("FAIL exit_first_latency: got index %0d need 0", fx);
        else passes++;
        checks++;
        if (fe != 2 * PULSE_CYC) $display("FAIL entry_after_gap: got index %0d need %0d", fe, 2 * PULSE_CYC);
        else passes++;
        checks++;
        if (nx != PULSE_CYC || ne != PULSE_CYC || ovl != 0)
            $display("FAIL dual_widths: got x=%0d e=%0d ovl=%0d need %0d/%0d/0", nx, ne, ovl, PULSE_CYC, PULSE_CYC);
        else passes++;
        checks++;
        if (tx !== xu || te !== eu) $display("FAIL dual_tags: got x=%b e=%b need %b/%b", tx, te, xu, eu);
        else passes++;
        entry_req = 0; exit_req = 0;
        repeat (4) tick();
    endtask

    task automatic test_timeout();
        int n, r0, rx;
        apply_reset();
        hour = 6'($urandom_range(23, OPEN_HOUR));
        is_vacated_space = 1; entry_is_uni = 0;
        r0 = ent_rises;
        entry_req = 1;
        n = 0;
        for (int i = 0; i < TIMEOUT_CYC + 10; i++) begin
            tick(); if (entry_gate_open === 1'b1) n++;
        end
        checks++;
        if (n != TIMEOUT_CYC) $display("FAIL entry_timeout_open: got %0d cycles need %0d", n, TIMEOUT_CYC);
        else passes++;
        entry_req = 0;
        repeat (3) tick();
        rx = ex_rises;
        exit_is_uni = 1'($urandom_range(1, 0));
        exit_req = 1;
        n = 0;
        for (int i = 0; i < TIMEOUT_CYC + 10; i++) begin
            tick(); if (exit_gate_open === 1'b1) n++;
        end
        checks++;
        if (n != TIMEOUT_CYC) $display("FAIL exit_timeout_open: got %0d cycles need %0d", n, TIMEOUT_CYC);
        else passes++;
        exit_req = 0;
        repeat (4) tick();
        checks++;
        if (ent_rises != r0 || ex_rises != rx)
            $display("FAIL timeout_no_pulse: got %0d/%0d new pulses need 0/0", ent_rises - r0, ex_rises - rx);
        else passes++;
`ifdef PARK_GATE_STATS_EN
        checks++;
        if (timeout_count !== 16'd2) $display("FAIL timeout_count: got %0d need 2", timeout_count);
        else passes++;
`endif
    endtask

    task automatic test_reset_mid_open();
        int r0;
        logic seen;
        hour = 9; is_vacated_space = 1; entry_is_uni = 0;
        entry_req = 1;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick(); seen = entry_gate_open;
        end
        tick();
        #2 rst_n = 0;
        #1;
        checks++;
        if (seen !== 1'b1 || entry_gate_open !== 1'b0)
            $display("FAIL reset_gate_async: got opened=%b gate=%b need 1/0", seen, entry_gate_open);
        else passes++;
        entry_req = 0;
        tick(); tick();
        rst_n = 1;
        r0 = ent_rises;
        entry_passed = 1; tick(); entry_passed = 0;
        repeat (8) tick();
        checks++;
        if (ent_rises != r0 || entry_gate_open !== 1'b0)
            $display("FAIL no_pulse_after_reset: got %0d pulses gate=%b need 0/0", ent_rises - r0, entry_gate_open);
        else passes++;
    endtask

    task automatic test_random_cars();
        logic uni, uf, pf, accepted, ok, gate_seen, got, tagv, seen;
        int deny_cyc;
        for (int k = 0; k < 12; k++) begin
            hour = 6'($urandom_range(23, 0));
            if ($urandom_range(1, 0) == 0) begin
                uni = 1'($urandom_range(1, 0)); uf = 1'($urandom_range(1, 0)); pf = 1'($urandom_range(1, 0));
                accepted = (int'(hour) >= OPEN_HOUR);
                ok = uni ? (uf | pf) : pf;
                entry_is_uni = uni; uni_is_vacated_space = uf; is_vacated_space = pf;
                entry_req = 1;
                gate_seen = 0; deny_cyc = 0;
                repeat (8) begin
                    tick();
                    gate_seen |= entry_gate_open;
                    if (entry_denied === 1'b1) deny_cyc++;
                end
                checks++;
                if (gate_seen !== (accepted & ok) || deny_cyc != ((accepted && !ok) ? 1 : 0))
                    $display("FAIL rand_entry_%0d: got gate=%b deny=%0d need %b/%0d", k, gate_seen, deny_cyc,
                             accepted & ok, (accepted && !ok) ? 1 : 0);
                else passes++;
                if (accepted && ok) begin
                    entry_passed = 1; tick(); entry_passed = 0;
                    got = 0; tagv = 0;
                    for (int j = 0; j < 10 && !got; j++) begin
                        tick();
                        if (car_entered === 1'b1) begin got = 1; tagv = is_uni_car_entered; end
                    end
                    checks++;
                    if (got !== 1'b1 || tagv !== uni) $display("FAIL rand_entry_tag_%0d: got %b/%b need 1/%b", k, got, tagv, uni);
                    else passes++;
                end
                entry_req = 0;
            end else begin
                uni = 1'($urandom_range(1, 0));
                exit_is_uni = uni;
                exit_req = 1;
                seen = 0;
                for (int j = 0; j < 4 && !seen; j++) begin
                    tick(); seen = exit_gate_open;
                end
                checks++;
                if (seen !== 1'b1) $display("FAIL rand_exit_gate_%0d: got %b need 1 (hour %0d)", k, seen, hour);
                else passes++;
                exit_passed = 1; tick(); exit_passed = 0;
                got = 0; tagv = 0;
                for (int j = 0; j < 10 && !got; j++) begin
                    tick();
                    if (car_exited === 1'b1) begin got = 1; tagv = is_uni_car_exited; end
                end
                checks++;
                if (got !== 1'b1 || tagv !== uni) $display("FAIL rand_exit_tag_%0d: got %b/%b need 1/%b", k, got, tagv, uni);
                else passes++;
                exit_req = 0;
            end
            repeat (6) tick();
        end
    endtask

    task automatic test_no_overlap();
        checks++;
        if (overlap_cnt != 0) $display("FAIL pulse_overlap: got %0d cycles need 0", overlap_cnt);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_public_entry();
        test_hour_gate();
        test_denied();
        test_both_pass();
        test_timeout();
        test_reset_mid_open();
        test_random_cars();
        test_no_overlap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
